// File: rtl/display_scan.sv
// Multiplexed 7-segment scanner with per-digit PWM dimming, leading-zero blanking and double-buffered capture.
// Optional blinking is enabled by defining DISPLAY_SCAN_BLINK_EN (adds i_blink and parameter BLINK_FRAMES).
module display_scan #(
`ifdef DISPLAY_SCAN_BLINK_EN
    parameter int BLINK_FRAMES = 64,
`endif
    parameter int DIGIT_NUM    = 8,
    parameter int CLK_DIV      = 1024
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [DIGIT_NUM*4-1:0] i_digits,
    input  logic                   i_sign,
    input  logic [3:0]             i_brightness,
    input  logic                   i_update,
`ifdef DISPLAY_SCAN_BLINK_EN
    input  logic                   i_blink,
`endif
    output logic [6:0]             o_seg,
    output logic                   o_dp,
    output logic [DIGIT_NUM-1:0]   o_dig_sel,
    output logic                   o_frame_done
);

    localparam int PH_LEN = CLK_DIV / 16;
    localparam int SUB_W  = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
    localparam int SLOT_W = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;

    // Cycle-in-slot is kept as {phase, sub} so the PWM phase needs no divider.
    logic [SUB_W-1:0]       r_sub;
    logic [3:0]             r_phase;
    logic [SLOT_W-1:0]      r_slot;
    logic [DIGIT_NUM*4-1:0] r_shadow_dig;
    logic                   r_shadow_sign;
    logic [DIGIT_NUM*4-1:0] r_active_dig;
    logic                   r_active_sign;

    logic [SUB_W-1:0]       w_sub_nxt;
    logic [3:0]             w_phase_nxt;
    logic [SLOT_W-1:0]      w_slot_nxt;
    logic                   w_sub_wrap;
    logic                   w_slot_wrap;
    logic                   w_frame_start;
    logic                   w_frame_done_nxt;
    logic                   w_lit;
    logic                   w_vis;
    logic [DIGIT_NUM-1:0]   w_sel_nxt;
    logic [DIGIT_NUM*4-1:0] w_src_dig;
    logic                   w_src_sign;
    logic [SLOT_W-1:0]      w_msd;
    logic                   w_nonzero;
    logic [3:0]             w_nib;
    logic [6:0]             w_seg_nxt;
    logic                   w_dp_nxt;

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    f_glyph = 7'h3F;
            4'h1:    f_glyph = 7'h06;
            4'h2:    f_glyph = 7'h5B;
            4'h3:    f_glyph = 7'h4F;
            4'h4:    f_glyph = 7'h66;
            4'h5:    f_glyph = 7'h6D;
            4'h6:    f_glyph = 7'h7D;
            4'h7:    f_glyph = 7'h07;
            4'h8:    f_glyph = 7'h7F;
            4'h9:    f_glyph = 7'h6F;
            4'hA:    f_glyph = 7'h77;
            4'hB:    f_glyph = 7'h7C;
            4'hC:    f_glyph = 7'h39;
            4'hD:    f_glyph = 7'h5E;
            4'hE:    f_glyph = 7'h79;
            default: f_glyph = 7'h71;
        endcase
    endfunction

    assign w_sub_wrap    = (r_sub == SUB_W'(PH_LEN - 1));
    assign w_sub_nxt     = w_sub_wrap ? '0 : r_sub + 1'b1;
    assign w_phase_nxt   = w_sub_wrap ? r_phase + 4'd1 : r_phase;
    assign w_slot_wrap   = w_sub_wrap && (r_phase == 4'd15);
    assign w_frame_start = w_slot_wrap && (r_slot == SLOT_W'(DIGIT_NUM - 1));
    assign w_slot_nxt    = w_frame_start ? '0 :
                           (w_slot_wrap ? r_slot + 1'b1 : r_slot);

    assign w_frame_done_nxt = (w_phase_nxt == 4'd15) && (w_sub_nxt == SUB_W'(PH_LEN - 1)) &&
                              (w_slot_nxt == SLOT_W'(DIGIT_NUM - 1));

    // The first cycle of each slot is always dark to avoid ghosting between digits.
    assign w_lit     = !w_slot_wrap && (w_phase_nxt <= i_brightness) && w_vis;
    assign w_sel_nxt = w_lit ? (DIGIT_NUM'(1) << w_slot_nxt) : '0;

    // At the frame-start edge the glyph must come from the value being promoted.
    assign w_src_dig  = w_frame_start ? r_shadow_dig  : r_active_dig;
    assign w_src_sign = w_frame_start ? r_shadow_sign : r_active_sign;

    always_comb begin
        w_msd     = '0;
        w_nonzero = 1'b0;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            if (w_src_dig[4*i +: 4] != 4'h0) begin
                w_msd     = SLOT_W'(i);
                w_nonzero = 1'b1;
            end
        end
    end

    assign w_nib = w_src_dig[{w_slot_nxt, 2'b00} +: 4];

    always_comb begin
        w_seg_nxt = 7'h00;
        if (w_slot_nxt <= w_msd) begin
            w_seg_nxt = f_glyph(w_nib);
        end else if (w_src_sign && w_nonzero &&
                     ({1'b0, w_slot_nxt} == ({1'b0, w_msd} + 1'b1))) begin
            w_seg_nxt = 7'h40;
        end
    end

    assign w_dp_nxt = w_src_sign && w_nonzero &&
                      (w_msd == SLOT_W'(DIGIT_NUM - 1)) &&
                      (w_slot_nxt == SLOT_W'(DIGIT_NUM - 1));

`ifdef DISPLAY_SCAN_BLINK_EN
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BC_W-1:0] r_blink_cnt;
    logic            r_hidden;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_blink_cnt <= '0;
            r_hidden    <= 1'b0;
        end else if (w_frame_start) begin
            if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt <= '0;
                r_hidden    <= !r_hidden;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_vis = !(i_blink && r_hidden);
`else
    assign w_vis = 1'b1;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sub         <= '0;
            r_phase       <= 4'd0;
            r_slot        <= '0;
            r_shadow_dig  <= '0;
            r_shadow_sign <= 1'b0;
            r_active_dig  <= '0;
            r_active_sign <= 1'b0;
            o_seg         <= 7'h00;
            o_dp          <= 1'b0;
            o_dig_sel     <= '0;
            o_frame_done  <= 1'b0;
        end else begin
            r_sub   <= w_sub_nxt;
            r_phase <= w_phase_nxt;
            r_slot  <= w_slot_nxt;
            if (i_update) begin
                r_shadow_dig  <= i_digits;
                r_shadow_sign <= i_sign;
            end
            if (w_frame_start) begin
                r_active_dig  <= r_shadow_dig;
                r_active_sign <= r_shadow_sign;
            end
            o_seg        <= w_seg_nxt;
            o_dp         <= w_dp_nxt;
            o_dig_sel    <= w_sel_nxt;
            o_frame_done <= w_frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan with DIGIT_NUM=8, CLK_DIV=32 (frame = 256 clocks, PWM phase = 2 clocks).
module tb_display_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digits;
    logic        sign;
    logic [3:0]  bright;
    logic        update;
`ifdef DISPLAY_SCAN_BLINK_EN
    logic        blink;
`endif
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  dig_sel;
    logic        frame_done;

    int t;
    int n_vec;
    int n_fail;

    typedef struct {
        logic [31:0]     dig;
        logic            sgn;
        logic [7:0][6:0] seg;
        logic [7:0]      dp;
    } vec_t;

    vec_t vtab [6];

    display_scan #(
`ifdef DISPLAY_SCAN_BLINK_EN
        .BLINK_FRAMES(2),
`endif
        .DIGIT_NUM(8),
        .CLK_DIV(32)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_digits     (digits),
        .i_sign       (sign),
        .i_brightness (bright),
        .i_update     (update),
`ifdef DISPLAY_SCAN_BLINK_EN
        .i_blink      (blink),
`endif
        .o_seg        (seg),
        .o_dp         (dp),
        .o_dig_sel    (dig_sel),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s t=%0d got %h expected %h", nm, t, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    task automatic chk_dark(input string nm);
        chk({nm, "_seg"}, {25'd0, seg}, 32'h0);
        chk({nm, "_dp"}, {31'd0, dp}, 32'h0);
        chk({nm, "_sel"}, {24'd0, dig_sel}, 32'h0);
        chk({nm, "_fd"}, {31'd0, frame_done}, 32'h0);
    endtask

    // Asserts reset a few ns after an edge, holds it over two edges, releases away from an edge.
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_dark("rst_async");
        repeat (2) @(posedge clk);
        #1 chk_dark("rst_hold");
        rst = 1'b0;
        t = 0;
    endtask

    initial begin
        int f_start;
        int c;
        int s;
        logic [7:0] e_sel;
        logic [3:0] blev [4];

        digits = '0;
        sign   = 1'b0;
        update = 1'b0;
        bright = 4'd15;
`ifdef DISPLAY_SCAN_BLINK_EN
        blink  = 1'b0;
`endif
        t      = 0;
        n_vec  = 0;
        n_fail = 0;

        vtab[0] = '{32'h00001234, 1'b1, {7'h00, 7'h00, 7'h00, 7'h40, 7'h06, 7'h5B, 7'h4F, 7'h66}, 8'h00};
        vtab[1] = '{32'h9ABCDEF1, 1'b1, {7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h06}, 8'h80};
        vtab[2] = '{32'h00000000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 8'h00};
        vtab[3] = '{32'h80000005, 1'b0, {7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h6D}, 8'h00};
        vtab[4] = '{32'h05060708, 1'b1, {7'h40, 7'h6D, 7'h3F, 7'h7D, 7'h3F, 7'h07, 7'h3F, 7'h7F}, 8'h00};
        vtab[5] = '{32'h00000010, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h06, 7'h3F}, 8'h00};
        blev[0] = 4'd0;
        blev[1] = 4'd7;
        blev[2] = 4'd15;
        blev[3] = 4'd3;

        // Power-on reset and first frame showing zero
        repeat (3) @(posedge clk);
        #1 chk_dark("por");
        rst = 1'b0;
        t   = 0;
        chk_dark("t0");
        digits = 32'h00001234;
        sign   = 1'b1;
        run_to(1);
        chk("t1_seg", {25'd0, seg}, 32'h3F);
        chk("t1_sel", {24'd0, dig_sel}, 32'h01);
        run_to(9);
        update = 1'b1;
        step();
        update = 1'b0;
        run_to(33);
        chk("f0_d1_seg", {25'd0, seg}, 32'h00);
        chk("f0_d1_sel", {24'd0, dig_sel}, 32'h02);
        run_to(254);
        chk("fd_254", {31'd0, frame_done}, 32'h0);
        step();
        chk("fd_255", {31'd0, frame_done}, 32'h1);
        chk("f0_d7_sel", {24'd0, dig_sel}, 32'h80);
        step();
        chk("fd_256", {31'd0, frame_done}, 32'h0);
        chk("t256_dead", {24'd0, dig_sel}, 32'h00);
        chk("t256_seg", {25'd0, seg}, 32'h66);
        run_to(256 + 4*32 + 1);
        chk("f1_minus", {25'd0, seg}, 32'h40);
        chk("f1_d4_sel", {24'd0, dig_sel}, 32'h10);
        run_to(256 + 5*32 + 1);
        chk("f1_blank5", {25'd0, seg}, 32'h00);

        // Update landing exactly on a frame-start edge
        run_to(300);
        digits = 32'h2;
        sign   = 1'b0;
        update = 1'b1;
        step();
        update = 1'b0;
        run_to(511);
        digits = 32'h3;
        update = 1'b1;
        step();
        update = 1'b0;
        chk("fs_upd_512", {25'd0, seg}, 32'h5B);
        run_to(513);
        chk("fs_upd_513", {25'd0, seg}, 32'h5B);
        run_to(769);
        chk("fs_upd_769", {25'd0, seg}, 32'h4F);

        // PWM duty per brightness level over one whole slot
        for (int b = 0; b < 4; b++) begin
            while ((t % 32) != 31) step();
            bright = blev[b];
            repeat (32) begin
                step();
                c = t % 32;
                s = (t / 32) % 8;
                e_sel = ((c != 0) && ((c / 2) <= int'(blev[b]))) ? (8'd1 << s) : 8'd0;
                chk($sformatf("pwm_b%0d_c%0d", blev[b], c), {24'd0, dig_sel}, {24'd0, e_sel});
            end
        end
        bright = 4'd15;

        // Glyph/blanking/sign table, checked one frame after capture
        for (int i = 0; i < 6; i++) begin
            if (((t + 1) % 256) == 0) step();
            digits = vtab[i].dig;
            sign   = vtab[i].sgn;
            update = 1'b1;
            step();
            update = 1'b0;
            f_start = ((t / 256) + 1) * 256;
            for (int d = 0; d < 8; d++) begin
                run_to(f_start + d*32 + 1);
                chk($sformatf("v%0d_d%0d_seg", i, d), {25'd0, seg}, {25'd0, vtab[i].seg[d]});
                chk($sformatf("v%0d_d%0d_dp", i, d), {31'd0, dp}, {31'd0, vtab[i].dp[d]});
                chk($sformatf("v%0d_d%0d_sel", i, d), {24'd0, dig_sel}, {24'd0, 8'd1 << d});
            end
        end

        // Reset in the middle of a frame clears value and counters
        run_to(t + 45);
        do_reset();
        run_to(1);
        chk("mr_t1_seg", {25'd0, seg}, 32'h3F);
        chk("mr_t1_sel", {24'd0, dig_sel}, 32'h01);
        run_to(33);
        chk("mr_t33_seg", {25'd0, seg}, 32'h00);
        run_to(254);
        chk("mr_fd_254", {31'd0, frame_done}, 32'h0);
        run_to(255);
        chk("mr_fd_255", {31'd0, frame_done}, 32'h1);

`ifdef DISPLAY_SCAN_BLINK_EN
        blink = 1'b1;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            run_to(f*256 + 1);
            chk($sformatf("blink_f%0d", f), {24'd0, dig_sel},
                ((f == 2) || (f == 3)) ? 32'h00 : 32'h01);
            if (f == 2) begin
                run_to(f*256 + 40);
                blink = 1'b0;
                step();
                chk("blink_off", {24'd0, dig_sel}, 32'h02);
                blink = 1'b1;
                step();
                chk("blink_on", {24'd0, dig_sel}, 32'h00);
            end
            run_to(f*256 + 255);
            chk($sformatf("blink_fd%0d", f), {31'd0, frame_done}, 32'h1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
